// File: rtl/alu_iter_exec_pkg.sv
// Shared types for the ALU execute stage: function codes from decode_alu and the
// execute FSM state encoding.
package alu_iter_exec_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_FUNC_ADD,
    ALU_FUNC_SUB,
    ALU_FUNC_SLT,
    ALU_FUNC_SLTU,
    ALU_FUNC_XOR,
    ALU_FUNC_AND,
    ALU_FUNC_SRL,
    ALU_FUNC_SRA,
    ALU_FUNC_SEQ,
    ALU_FUNC_UNKNOWN
  } alu_func_t;

  typedef enum logic [1:0] {
    EXEC_IDLE,
    EXEC_SHIFT,
    EXEC_DONE
  } exec_state_t;

  function automatic logic is_shift_func(input alu_func_t func);
    return (func == ALU_FUNC_SRL) || (func == ALU_FUNC_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Operation/result handshake bundle between the pipeline controller (master) and
// the ALU execute stage (slave).
interface alu_iter_exec_if
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
);
  // Both sides use strict valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the sender keeps valid and its payload stable until that edge.
  logic            in_valid;
  logic            in_ready;
  alu_func_t       in_func;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_err;

  modport master (
    output in_valid, in_func, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_func, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_iter_exec_alu_comb.sv
// Purely combinational single-cycle ALU ops. Shift functions are handled elsewhere
// and return zero here without flagging an error.
module alu_comb
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  alu_func_t       func,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (func)
      ALU_FUNC_ADD:  result = a + b;
      ALU_FUNC_SUB:  result = a - b;
      ALU_FUNC_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_FUNC_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_FUNC_XOR:  result = a ^ b;
      ALU_FUNC_AND:  result = a & b;
      ALU_FUNC_SEQ:  result = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_FUNC_SRL,
      ALU_FUNC_SRA:  result = '0;
      default:       err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// ALU execute stage: single-cycle ops via alu_comb, SRL/SRA via a 1-bit-per-cycle
// iterative shifter. Results are registered and held until the consumer takes them.
module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_iter_exec_if.slave       io,
  output logic                 busy,
  output exec_state_t          state_dbg
);

  exec_state_t        state_q, state_d;
  logic [XLEN-1:0]    acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               arith_q;
  logic [XLEN-1:0]    result_q;
  logic               err_q;

  logic [XLEN-1:0]    comb_result;
  logic               comb_err;
  logic [XLEN-1:0]    acc_shifted;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_is_shift;
  logic               accept;

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .func   (io.in_func),
    .a      (io.in_a),
    .b      (io.in_b),
    .result (comb_result),
    .err    (comb_err)
  );

  assign in_shamt    = io.in_b[SHAMT_W-1:0];
  assign in_is_shift = is_shift_func(io.in_func);
  assign accept      = io.in_valid && io.in_ready;
  assign acc_shifted = {(arith_q ? acc_q[XLEN-1] : 1'b0), acc_q[XLEN-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EXEC_IDLE;
    else        state_q <= state_d;
  end

  // DONE behaves like IDLE when the result is consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EXEC_IDLE,
      EXEC_DONE: begin
        if (accept) begin
          if (in_is_shift && (in_shamt != '0)) state_d = EXEC_SHIFT;
          else                                 state_d = EXEC_DONE;
        end else if ((state_q == EXEC_DONE) && io.out_ready) begin
          state_d = EXEC_IDLE;
        end
      end
      EXEC_SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) state_d = EXEC_DONE;
      end
      default: state_d = EXEC_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      EXEC_IDLE: begin
        io.in_ready = 1'b1;
        busy        = 1'b0;
      end
      EXEC_SHIFT: ;
      EXEC_DONE: begin
        io.out_valid = 1'b1;
        io.in_ready  = io.out_ready;
      end
      default: ;
    endcase
  end

  // A shift with shamt 0 completes immediately with the unshifted operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      arith_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (in_is_shift) begin
        acc_q    <= io.in_a;
        cnt_q    <= in_shamt;
        arith_q  <= (io.in_func == ALU_FUNC_SRA);
        result_q <= io.in_a;
        err_q    <= 1'b0;
      end else begin
        result_q <= comb_result;
        err_q    <= comb_err;
      end
    end else if (state_q == EXEC_SHIFT) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) result_q <= acc_shifted;
    end
  end

  assign io.out_result = result_q;
  assign io.out_err    = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: scoreboard of expected {err,result} pairs plus
// latency, stall and reset checks.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;

  localparam int XLEN = 32;

  logic        clk;
  logic        rst_n;
  logic        busy;
  exec_state_t state_dbg;

  logic [XLEN:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_iter_exec_if #(.XLEN(XLEN)) bus ();

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN:0] got, input logic [XLEN:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // independent reference for every function
  function automatic logic [XLEN:0] model(input alu_func_t f, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      ALU_FUNC_ADD:  return {1'b0, a + b};
      ALU_FUNC_SUB:  return {1'b0, a - b};
      ALU_FUNC_SLT:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      ALU_FUNC_SLTU: return {1'b0, 31'd0, (a < b)};
      ALU_FUNC_XOR:  return {1'b0, a ^ b};
      ALU_FUNC_AND:  return {1'b0, a & b};
      ALU_FUNC_SRL:  return {1'b0, a >> sh};
      ALU_FUNC_SRA:  return {1'b0, $unsigned($signed(a) >>> sh)};
      ALU_FUNC_SEQ:  return {1'b0, 31'd0, (a == b)};
      default:       return {1'b1, 32'd0};
    endcase
  endfunction

  // driver: called at a negedge, returns at the negedge after the accepting edge
  task automatic drive_op(input alu_func_t f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output int waited);
    exp_q.push_back(model(f, a, b));
    bus.in_valid = 1'b1;
    bus.in_func  = f;
    bus.in_a     = a;
    bus.in_b     = b;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) chk("accept_timeout", 33'(waited), 33'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  // scoreboard: compare whenever a result is consumed
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {bus.out_err, bus.out_result}, 33'h1_DEAD_BEEF);
      end else begin
        chk("result", {bus.out_err, bus.out_result}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int w;
    int cyc;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_func  = ALU_FUNC_ADD;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 33'(bus.out_valid), 33'd0);
    chk("rst_result", {bus.out_err, bus.out_result}, 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_in_ready", 33'(bus.in_ready), 33'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: wrap-around add/sub, 1-cycle latency
    drive_op(ALU_FUNC_ADD, 32'hFFFF_FFFF, 32'd1, w);
    chk("add_latency", 33'(bus.out_valid), 33'd1);
    drain(10);
    drive_op(ALU_FUNC_SUB, 32'd0, 32'd1, w);
    chk("sub_latency", 33'(bus.out_valid), 33'd1);
    drain(10);

    // 2: compares
    drive_op(ALU_FUNC_SLT, 32'hFFFF_FFFE, 32'd1, w);
    drain(10);
    drive_op(ALU_FUNC_SLTU, 32'hFFFF_FFFE, 32'd1, w);
    drain(10);
    drive_op(ALU_FUNC_SEQ, 32'h1234, 32'h1234, w);
    drain(10);

    // 3: iterative shifts; count cycles between accept and out_valid
    drive_op(ALU_FUNC_SRA, 32'h8000_0000, 32'd31, w);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (cyc == 5) chk("sra_busy", 33'(busy), 33'd1);
      cyc++;
      @(negedge clk);
    end
    chk("sra_shift_cycles", 33'(cyc), 33'd31);
    drain(10);
    drive_op(ALU_FUNC_SRL, 32'h8000_0000, 32'd31, w);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("srl_shift_cycles", 33'(cyc), 33'd31);
    drain(10);
    drive_op(ALU_FUNC_SRL, 32'hCAFE_F00D, 32'd32, w);
    chk("srl_shamt0_latency", 33'(bus.out_valid), 33'd1);
    drain(10);
    drive_op(ALU_FUNC_SRA, 32'hF000_00F0, 32'h0000_0104, w);
    drain(20);

    // 4: back-to-back, then a held result with a stalled upstream op
    drive_op(ALU_FUNC_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, w);
    drive_op(ALU_FUNC_AND, 32'hA5A5_0F0F, 32'h0FF0_FFFF, w);
    chk("b2b_no_wait_1", 33'(w), 33'd0);
    drive_op(ALU_FUNC_XOR, 32'h1234_5678, 32'h1234_5678, w);
    chk("b2b_no_wait_2", 33'(w), 33'd0);
    drive_op(ALU_FUNC_AND, 32'(44'(44'h1_0000_0000 >> 8)), 32'hFFFF_FFFF, w);
    chk("b2b_no_wait_3", 33'(w), 33'd0);
    drain(10);

    bus.out_ready = 1'b0;
    drive_op(ALU_FUNC_SUB, 32'd10, 32'd3, w);
    exp_q.push_back(model(ALU_FUNC_ADD, 32'd1, 32'd1));
    bus.in_valid = 1'b1;
    bus.in_func  = ALU_FUNC_ADD;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", 33'(bus.out_valid), 33'd1);
      chk("stall_result", {bus.out_err, bus.out_result}, 33'd7);
      chk("stall_in_ready", 33'(bus.in_ready), 33'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain(10);

    // 5: unknown op flags error; next op clears it
    drive_op(ALU_FUNC_UNKNOWN, 32'h1111_1111, 32'h2222_2222, w);
    chk("unknown_err", {bus.out_err, bus.out_result}, 33'h1_0000_0000);
    drain(10);
    drive_op(ALU_FUNC_ADD, 32'd2, 32'd3, w);
    drain(10);

    // 6: reset in the middle of a 10-bit SRL
    drive_op(ALU_FUNC_SRL, 32'hFFFF_0000, 32'd10, w);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 33'(busy), 33'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 33'(bus.out_valid), 33'd0);
    chk("mid_rst_busy", 33'(busy), 33'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) chk("stale_after_rst", 33'(bus.out_valid), 33'd0);
    end
    chk("post_rst_idle", 33'(state_dbg), 33'(EXEC_IDLE));
    drive_op(ALU_FUNC_ADD, 32'd7, 32'd8, w);
    chk("post_rst_add", {bus.out_err, bus.out_result}, 33'd15);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
